// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/grant/response plus the decode handoff.
interface ifu_fetch_if #(
    parameter int INST_W = 32
);
    logic              imem_req;
    logic [63:0]       imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;
    logic              ivalid;
    logic [INST_W-1:0] inst;
    logic [63:0]       inst_pc;
    logic              pipe2_allowin;

    modport master (
        output imem_req, imem_addr, ivalid, inst, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, pipe2_allowin
    );

    modport slave (
        input  imem_req, imem_addr, ivalid, inst, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, pipe2_allowin
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: PC generation, single-outstanding imem handshake, decode handoff.
// Optional macro IFU_PERF_EN adds fetch/flush performance counters.
module ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          INST_W   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        if_en,
`ifdef IFU_PERF_EN
    output logic [63:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt,
`endif
    ifu_fetch_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } state_t;

    state_t            state_r, state_nxt_s, resume_s;
    logic [63:0]       pc_r, pc_nxt_s;
    logic [63:0]       req_pc_r, req_pc_nxt_s;
    logic [63:0]       inst_pc_r, inst_pc_nxt_s;
    logic [INST_W-1:0] inst_r, inst_nxt_s;
    logic              ivalid_r, ivalid_nxt_s;
    logic              req_r;
    logic              redir_q_r;
    logic              new_redir_s;
    logic              fetch_s;
    logic              flush_s;

    // Only the rising edge of the held redirect level acts on the PC.
    assign new_redir_s = redirect & ~redir_q_r;
    assign resume_s    = if_en ? ST_REQ : ST_IDLE;

    // State, PC and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            pc_r      <= RESET_PC;
            req_pc_r  <= 64'd0;
            inst_pc_r <= 64'd0;
            inst_r    <= {INST_W{1'b0}};
            ivalid_r  <= 1'b0;
            req_r     <= 1'b0;
            redir_q_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pc_r      <= pc_nxt_s;
            req_pc_r  <= req_pc_nxt_s;
            inst_pc_r <= inst_pc_nxt_s;
            inst_r    <= inst_nxt_s;
            ivalid_r  <= ivalid_nxt_s;
            req_r     <= (state_nxt_s == ST_REQ);
            redir_q_r <= redirect;
        end
    end

    // Next-state, PC selection and flush decisions.
    always_comb begin
        state_nxt_s   = state_r;
        pc_nxt_s      = pc_r;
        req_pc_nxt_s  = req_pc_r;
        inst_pc_nxt_s = inst_pc_r;
        inst_nxt_s    = inst_r;
        ivalid_nxt_s  = ivalid_r;
        flush_s       = 1'b0;
        fetch_s       = ivalid_r & bus.pipe2_allowin;
        case (state_r)
            ST_IDLE: begin
                if (new_redir_s) begin
                    pc_nxt_s = redirect_pc;
                end else begin
                    pc_nxt_s = pc_r;
                end
                state_nxt_s = resume_s;
            end
            ST_REQ: begin
                if (bus.imem_gnt) begin
                    req_pc_nxt_s = pc_r;
                    if (new_redir_s) begin
                        // Granted fetch is already in flight: its response must be dropped.
                        pc_nxt_s    = redirect_pc;
                        flush_s     = 1'b1;
                        state_nxt_s = ST_DROP;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end else if (new_redir_s) begin
                    pc_nxt_s = redirect_pc;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (new_redir_s) begin
                    pc_nxt_s    = redirect_pc;
                    flush_s     = 1'b1;
                    state_nxt_s = bus.imem_rvalid ? resume_s : ST_DROP;
                end else if (bus.imem_rvalid) begin
                    inst_nxt_s    = bus.imem_rdata;
                    inst_pc_nxt_s = req_pc_r;
                    ivalid_nxt_s  = 1'b1;
                    state_nxt_s   = ST_HOLD;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (new_redir_s) begin
                    pc_nxt_s = redirect_pc;
                end else begin
                    pc_nxt_s = pc_r;
                end
                if (bus.imem_rvalid) begin
                    state_nxt_s = resume_s;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            ST_HOLD: begin
                if (new_redir_s) begin
                    // A same-cycle accept still counts as delivered, so no flush then.
                    ivalid_nxt_s = 1'b0;
                    pc_nxt_s     = redirect_pc;
                    flush_s      = ~bus.pipe2_allowin;
                    state_nxt_s  = resume_s;
                end else if (bus.pipe2_allowin) begin
                    ivalid_nxt_s = 1'b0;
                    pc_nxt_s     = inst_pc_r + 64'd4;
                    state_nxt_s  = resume_s;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                ivalid_nxt_s = 1'b0;
            end
        endcase
    end

    assign bus.imem_req  = req_r;
    assign bus.imem_addr = pc_r;
    assign bus.ivalid    = ivalid_r;
    assign bus.inst      = inst_r;
    assign bus.inst_pc   = inst_pc_r;

`ifdef IFU_PERF_EN
    // Performance counters for accepted fetches and flushed fetches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_cnt <= 64'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (fetch_s) begin
                perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            end
            if (flush_s) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`else
    logic perf_unused_s;
    assign perf_unused_s = fetch_s ^ flush_s;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: memory model grants requests, monitors check addresses and deliveries.
module tb_ifu_fetch;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } del_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        if_en;
`ifdef IFU_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    ifu_fetch_if #(.INST_W(32)) bus ();

    ifu_fetch #(.RESET_PC(RST_PC), .INST_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .if_en         (if_en),
`ifdef IFU_PERF_EN
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_flush_cnt(perf_flush_cnt),
`endif
        .bus           (bus)
    );

    always #5 clk = ~clk;

    logic [63:0] exp_addr[$];
    del_t        exp_del[$];
    int          vec_cnt = 0;
    int          miss_cnt = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // Memory model: immediate grant, response rv_dly cycles later, data = addr ^ DEAD0000.
    bit          pending = 1'b0;
    logic [63:0] pend_addr;
    int          rv_cnt = 0;
    int          rv_dly = 1;
    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            bus.imem_gnt    = 1'b0;
            bus.imem_rvalid = 1'b0;
            if (pending) begin
                chk("single_outstanding_req", 64'(bus.imem_req), 64'd0);
                if (rv_cnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = pend_addr[31:0] ^ 32'hDEAD_0000;
                    pending         = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end else if (rst_n === 1'b1 && bus.imem_req === 1'b1) begin
                bus.imem_gnt = 1'b1;
                pending      = 1'b1;
                pend_addr    = bus.imem_addr;
                rv_cnt       = rv_dly - 1;
                if (exp_addr.size() == 0) begin
                    vec_cnt++;
                    miss_cnt++;
                    $display("FAIL req_addr: unexpected request at %h, required none", bus.imem_addr);
                end else begin
                    chk("req_addr", bus.imem_addr, exp_addr.pop_front());
                end
            end
        end
    end

    // Delivery monitor: every accepted instruction must be the next expected one.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.ivalid === 1'b1 && bus.pipe2_allowin === 1'b1) begin
            if (exp_del.size() == 0) begin
                vec_cnt++;
                miss_cnt++;
                $display("FAIL deliver: unexpected inst_pc %h inst %h, required none", bus.inst_pc, bus.inst);
            end else begin
                del_t e;
                e = exp_del.pop_front();
                chk("deliver_pc", bus.inst_pc, e.pc);
                chk("deliver_inst", 64'(bus.inst), 64'(e.inst));
            end
        end
    end

    task automatic wait_ivalid(input string nm);
        int n = 0;
        while (bus.ivalid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk(nm, 64'(bus.ivalid), 64'd1);
    endtask

    task automatic wait_del_size(input int sz, input string nm);
        int n = 0;
        while (exp_del.size() > sz && n < 60) begin
            tick();
            n++;
        end
        chk(nm, 64'(exp_del.size()), 64'(sz));
    endtask

    task automatic wait_gnt(input string nm);
        int n = 0;
        do begin
            tick();
            n++;
        end while (bus.imem_gnt !== 1'b1 && n < 30);
        chk(nm, 64'(bus.imem_gnt), 64'd1);
    endtask

    initial begin
        int req_cyc;
        int iv_cyc;
        rst_n             = 1'b0;
        if_en             = 1'b0;
        redirect          = 1'b0;
        redirect_pc       = 64'd0;
        bus.pipe2_allowin = 1'b0;
        repeat (3) tick();
        chk("rst_req", 64'(bus.imem_req), 64'd0);
        chk("rst_addr", bus.imem_addr, RST_PC);
        chk("rst_ivalid", 64'(bus.ivalid), 64'd0);
        chk("rst_inst", 64'(bus.inst), 64'd0);
        chk("rst_inst_pc", bus.inst_pc, 64'd0);

        // Sequential fetch: two delivered, the third held.
        exp_addr.push_back(64'h8000_0000);
        exp_addr.push_back(64'h8000_0004);
        exp_addr.push_back(64'h8000_0008);
        exp_del.push_back('{64'h8000_0000, 32'h5EAD_0000});
        exp_del.push_back('{64'h8000_0004, 32'h5EAD_0004});
        exp_del.push_back('{64'h8000_0008, 32'h5EAD_0008});
        bus.pipe2_allowin = 1'b1;
        if_en             = 1'b1;
        rst_n             = 1'b1;
        req_cyc = -1;
        iv_cyc  = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (req_cyc < 0 && bus.imem_req === 1'b1) req_cyc = cyc;
            if (iv_cyc < 0 && bus.ivalid === 1'b1) begin
                iv_cyc = cyc;
                break;
            end
        end
        chk("req_to_ivalid_latency", 64'(iv_cyc - req_cyc), 64'd2);
        wait_del_size(1, "seq_two_delivered");
        bus.pipe2_allowin = 1'b0;
        wait_ivalid("hold_entry");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_ivalid", 64'(bus.ivalid), 64'd1);
            chk("hold_inst_pc", bus.inst_pc, 64'h8000_0008);
            chk("hold_inst", 64'(bus.inst), 64'h5EAD_0008);
            chk("hold_no_req", 64'(bus.imem_req), 64'd0);
        end

        // Redirect while WAIT; level held for 10 cycles.
        exp_addr.push_back(64'h8000_000C);
        exp_addr.push_back(64'h8000_1000);
        exp_addr.push_back(64'h8000_1004);
        exp_addr.push_back(64'h8000_1008);
        exp_del.push_back('{64'h8000_1000, 32'h5EAD_1000});
        exp_del.push_back('{64'h8000_1004, 32'h5EAD_1004});
        exp_del.push_back('{64'h8000_1008, 32'h5EAD_1008});
        rv_dly            = 4;
        bus.pipe2_allowin = 1'b1;
        wait_gnt("gnt_before_wait_redirect");
        tick();
        redirect    = 1'b1;
        redirect_pc = 64'h8000_1000;
        rv_dly      = 1;
        repeat (10) tick();
        redirect = 1'b0;
        wait_del_size(1, "redirect_two_delivered");
        bus.pipe2_allowin = 1'b0;
        wait_ivalid("hold2_entry");

        // if_en low during HOLD: accept, then no further requests.
        if_en = 1'b0;
        tick();
        bus.pipe2_allowin = 1'b1;
        tick();
        bus.pipe2_allowin = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("if_en_off_no_req", 64'(bus.imem_req), 64'd0);
            chk("if_en_off_ivalid", 64'(bus.ivalid), 64'd0);
        end
        chk("hold2_delivered", 64'(exp_del.size()), 64'd0);

        // Redirect coincident with grant in REQ.
        exp_addr.push_back(64'h8000_100C);
        exp_addr.push_back(64'h8000_2000);
        exp_del.push_back('{64'h8000_2000, 32'h5EAD_2000});
        rv_dly      = 3;
        redirect_pc = 64'h8000_2000;
        if_en       = 1'b1;
        wait_gnt("gnt_with_redirect");
        redirect = 1'b1;
        wait_ivalid("drop_then_target");
        redirect          = 1'b0;
        if_en             = 1'b0;
        bus.pipe2_allowin = 1'b1;
        tick();
        bus.pipe2_allowin = 1'b0;
        repeat (5) tick();
        chk("final_ivalid", 64'(bus.ivalid), 64'd0);
        chk("final_req", 64'(bus.imem_req), 64'd0);
        chk("exp_addr_drained", 64'(exp_addr.size()), 64'd0);
        chk("exp_del_drained", 64'(exp_del.size()), 64'd0);
`ifdef IFU_PERF_EN
        chk("perf_fetch_cnt", perf_fetch_cnt, 64'd7);
        chk("perf_flush_cnt", 64'(perf_flush_cnt), 64'd2);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction-fetch front end. It consumes the redirect and enable outputs of the pipeline controller, and generates the sequential or redirected PC. It runs a single-outstanding request/grant/response handshake to instruction memory. Fetched instructions go to decode (pipe stage 2) through an ivalid/allowin handshake; completing that handshake releases the controller's redirect state.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset
INST_W, 32, instruction width in bits

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
redirect  input  1  level redirect request from controller; held until the target instruction is accepted downstream
redirect_pc  input  64  redirect target, stable while redirect=1
if_en  input  1  fetch enable (controller stall vector IF bit); 0 blocks new requests
imem_req  output  1  memory request valid
imem_addr  output  64  request address (PC)
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response valid (at least one cycle after gnt)
imem_rdata  input  INST_W  response data
ivalid  output  1  instruction valid to decode
inst  output  INST_W  fetched instruction
inst_pc  output  64  PC of inst
pipe2_allowin  input  1  decode accepts this cycle

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. On reset: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, ivalid=0, inst=0, inst_pc=0, redir_q=0.
- Redirect is edge-acted. redir_q registers redirect every cycle. A new redirect is redirect & !redir_q; only then are pc and the flush logic affected. The held level is otherwise ignored.
- States: IDLE, REQ, WAIT, HOLD, DROP.
- IDLE: if if_en=1 go to REQ next cycle.
- REQ: imem_req=1, imem_addr=pc.
  - gnt=1 → WAIT, and save req_pc=pc.
  - New redirect with no gnt: pc=redirect_pc and stay in REQ. The address changes next cycle, and the ungranted request is abandoned.
  - New redirect with gnt in the same cycle: pc=redirect_pc → DROP.
- WAIT: imem_req=0.
  - rvalid without redirect: inst=rdata, inst_pc=req_pc, ivalid=1 → HOLD.
  - New redirect before or with rvalid: pc=redirect_pc. Without rvalid → DROP. With rvalid → response discarded → REQ (if if_en=1) else IDLE.
- DROP: wait for the stale rvalid, discard it, then go to REQ if if_en=1 else IDLE. No ivalid is raised.
- HOLD: ivalid=1 and inst/inst_pc are stable until accepted.
  - pipe2_allowin=1: ivalid=0, pc=inst_pc+4 (mod 2^64, wraps), → REQ if if_en=1 else IDLE.
  - New redirect in HOLD: ivalid=0 the next cycle even if allowin=1 that cycle (the transfer still counts when allowin=1). pc=redirect_pc → REQ/IDLE per if_en.
- Sequential PC is always inst_pc+4; no compressed instructions.
- if_en=0 stops only REQ entry. An already-granted request completes through WAIT/HOLD normally. A request in REQ that is not yet granted stays asserted (it is not withdrawn).
- ivalid&pipe2_allowin occurs at most once per fetched instruction. Latency with gnt on the first request cycle and rvalid one cycle later: REQ→ivalid = 2 cycles.
- Exactly one outstanding imem transaction at any time.
- Reset mid-transaction returns to IDLE. Any later stray rvalid in IDLE/REQ is ignored.

Optional Feature:
IFU_PERF_EN: when defined, adds outputs perf_fetch_cnt[63:0] and perf_flush_cnt[31:0], both reset to 0.
- perf_fetch_cnt increments on each ivalid&pipe2_allowin.
- perf_flush_cnt increments on each new redirect that discards a granted or held instruction.
When not defined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, if_en=1, gnt immediate, rvalid next cycle, allowin=1 → addrs 0x80000000, 0x80000004, 0x80000008 issued; inst_pc matches each; ivalid first rises 2 cycles after REQ entry.
- allowin=0 for 5 cycles in HOLD → ivalid stays 1, inst/inst_pc unchanged, no imem_req.
- Redirect to 0x80001000 while in WAIT, rvalid 3 cycles later → stale data never shown; next imem_addr=0x80001000, delivered inst_pc=0x80001000.
- redirect held high 10 cycles → exactly one flush; subsequent fetches 0x80001000, 0x80001004 proceed while redirect is still high.
- Redirect coincident with gnt in REQ → DROP, stale rvalid discarded, then request at the target.
- if_en=0 while in HOLD → after accept, no imem_req until if_en=1. With IFU_PERF_EN, fetch/flush counters match the scenario counts.
